// File: rtl/wb_pkg.sv
// Shared Wishbone B3 definitions: bridge state encoding, fixed request field values
// and a counter-width helper.
package wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUS,
        GAP,
        DONE,
        RELEASE
    } bridge_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [3:0] WB_SEL_ALL     = 4'hF;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    // Bits needed to count from 0 up to n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B3 bus and processor debug port bundles used inside the bridge.
interface wishbone_b3 #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_m2s;
    logic [DW-1:0] dat_s2m;
    logic          we;
    logic [3:0]    sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          cyc;
    logic          stb;
    logic          ack;
    logic          err;
    logic          rty;

    modport master (output adr, dat_m2s, we, sel, cti, bte, cyc, stb,
                    input  dat_s2m, ack, err, rty);
    modport slave  (input  adr, dat_m2s, we, sel, cti, bte, cyc, stb,
                    output dat_s2m, ack, err, rty);
endinterface

interface debug_interface #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    logic          ack;
    logic          err;

    modport master (output stb, we, adr, wdat, input  rdat, ack, err);
    modport slave  (input  stb, we, adr, wdat, output rdat, ack, err);
endinterface

// File: rtl/wb_dbg_cnt.sv
// Loadable up-counter that saturates at all-ones and flags when it equals TC.
module wb_dbg_cnt #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TC    = '1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/wb_dbg_bridge.sv
// Debug-port to Wishbone B3 master: one classic single-beat cycle per debug strobe,
// with bounded retries, a response timeout and error reporting back to the debug side.
module wb_dbg_bridge
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3,
    parameter int RETRY_GAP  = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dbg_stb,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_adr,
    input  logic [DATA_WIDTH-1:0] dbg_wdat,
    output logic [DATA_WIDTH-1:0] dbg_rdat,
    output logic                  dbg_ack,
    output logic                  dbg_err,
    output logic [ADDR_WIDTH-1:0] wb_adr,
    output logic [DATA_WIDTH-1:0] wb_dat_m2s,
    output logic                  wb_we,
    output logic [3:0]            wb_sel,
    output logic [2:0]            wb_cti,
    output logic [1:0]            wb_bte,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    input  logic [DATA_WIDTH-1:0] wb_dat_s2m,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    input  logic                  wb_rty
);

    localparam int TW = cnt_width(TIMEOUT);
    localparam int GW = cnt_width(RETRY_GAP);
    localparam int RW = cnt_width(MAX_RETRY + 1);
    localparam logic [TW-1:0] TMO_TC   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_TC   = GW'(RETRY_GAP - 1);
    localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRY);

    wishbone_b3     #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_wb  ();
    debug_interface #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_dbg ();

    assign u_dbg.stb  = dbg_stb;
    assign u_dbg.we   = dbg_we;
    assign u_dbg.adr  = dbg_adr;
    assign u_dbg.wdat = dbg_wdat;
    assign dbg_rdat   = u_dbg.rdat;
    assign dbg_ack    = u_dbg.ack;
    assign dbg_err    = u_dbg.err;

    assign wb_adr        = u_wb.adr;
    assign wb_dat_m2s    = u_wb.dat_m2s;
    assign wb_we         = u_wb.we;
    assign wb_sel        = u_wb.sel;
    assign wb_cti        = u_wb.cti;
    assign wb_bte        = u_wb.bte;
    assign wb_cyc        = u_wb.cyc;
    assign wb_stb        = u_wb.stb;
    assign u_wb.dat_s2m  = wb_dat_s2m;
    assign u_wb.ack      = wb_ack;
    assign u_wb.err      = wb_err;
    assign u_wb.rty      = wb_rty;

    bridge_state_t         r_state;
    bridge_state_t         w_next;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_wdat;
    logic [DATA_WIDTH-1:0] r_rdat;
    logic [RW-1:0]         r_retry_cnt;
    logic                  r_err;
    logic                  w_tmo_tc;
    logic                  w_gap_tc;
    logic                  w_retry_max;
    logic                  w_retry;
    logic                  w_bus_fail;
    logic                  w_rd_cap;
    logic                  w_capture;
    logic                  w_bus_enter;

    assign w_retry_max = (r_retry_cnt == RETRY_MX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (u_dbg.stb) w_next = BUS;
            BUS: begin
                if (u_wb.err)
                    w_next = DONE;
                else if (u_wb.rty)
                    w_next = w_retry_max ? DONE : GAP;
                else if (u_wb.ack || w_tmo_tc)
                    w_next = DONE;
            end
            GAP:     if (w_gap_tc) w_next = BUS;
            DONE:    w_next = RELEASE;
            RELEASE: if (!u_dbg.stb) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Responses are decoded in priority order err > rty > ack > timeout.
    always_comb begin
        w_capture   = (r_state == IDLE) && u_dbg.stb;
        w_bus_enter = (w_next == BUS) && (r_state != BUS);
        w_retry     = (r_state == BUS) && !u_wb.err && u_wb.rty && !w_retry_max;
        w_bus_fail  = (r_state == BUS) && (u_wb.err || (u_wb.rty && w_retry_max) ||
                      (!u_wb.rty && !u_wb.ack && w_tmo_tc));
        w_rd_cap    = (r_state == BUS) && !u_wb.err && !u_wb.rty && u_wb.ack && !r_we;

        u_wb.cyc     = (r_state == BUS);
        u_wb.stb     = (r_state == BUS);
        u_wb.adr     = r_adr;
        u_wb.dat_m2s = r_wdat;
        u_wb.we      = r_we;
        u_wb.sel     = WB_SEL_ALL;
        u_wb.cti     = WB_CTI_CLASSIC;
        u_wb.bte     = WB_BTE_LINEAR;

        u_dbg.ack  = (r_state == DONE);
        u_dbg.err  = (r_state == DONE) && r_err;
        u_dbg.rdat = ((r_state == DONE) && !r_err && !r_we) ? r_rdat : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_wdat      <= '0;
            r_rdat      <= '0;
            r_retry_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_capture) begin
                r_we        <= u_dbg.we;
                r_adr       <= u_dbg.adr;
                r_wdat      <= u_dbg.wdat;
                r_retry_cnt <= '0;
                r_err       <= 1'b0;
            end
            if (w_retry)
                r_retry_cnt <= r_retry_cnt + 1'b1;
            if (w_bus_fail)
                r_err <= 1'b1;
            if (w_rd_cap)
                r_rdat <= u_wb.dat_s2m;
            if ((r_state == RELEASE) && !u_dbg.stb)
                r_err <= 1'b0;
        end
    end

    // Cycles spent in BUS since the last (re-)issue.
    wb_dbg_cnt #(.WIDTH(TW), .TC(TMO_TC)) u_tmo_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_bus_enter),
        .i_load_val ('0),
        .i_en       (r_state == BUS),
        .o_tc       (w_tmo_tc)
    );

    // Idle cycles between an rty and the re-issued cycle.
    wb_dbg_cnt #(.WIDTH(GW), .TC(GAP_TC)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_retry),
        .i_load_val ('0),
        .i_en       (r_state == GAP),
        .o_tc       (w_gap_tc)
    );

endmodule

// File: tb/tb_wb_dbg_bridge.sv
// Scoreboard bench for wb_dbg_bridge: directed debug accesses against a scripted slave.
module tb_wb_dbg_bridge;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dbg_stb, dbg_we;
    logic [31:0] dbg_adr, dbg_wdat, dbg_rdat;
    logic        dbg_ack, dbg_err;
    logic [31:0] wb_adr, wb_dat_m2s;
    logic        wb_we, wb_cyc, wb_stb;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_s2m = 32'h0;
    logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;

    always #5 clk = ~clk;

    wb_dbg_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_stb(dbg_stb), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdat(dbg_wdat),
        .dbg_rdat(dbg_rdat), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
        .wb_adr(wb_adr), .wb_dat_m2s(wb_dat_m2s), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
        .wb_dat_s2m(wb_dat_s2m), .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty)
    );

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int cyc_no = 0;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    // Scoreboard: expected debug responses, popped on every dbg_ack.
    typedef struct { logic err; logic [31:0] rdat; } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;
    int   n_acks = 0, t_ack = 0;

    always @(negedge clk) begin
        if (dbg_ack) begin
            n_acks++;
            t_ack = cyc_no;
            if (sb_q.size() == 0)
                check("unexpected_ack", 1, 0);
            else begin
                sb_e = sb_q.pop_front();
                check("dbg_err", dbg_err, sb_e.err);
                check("dbg_rdat", dbg_rdat, sb_e.rdat);
            end
        end
    end

    // Scripted slave plus bus monitor.
    localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_AE = 3;
    typedef struct { int kind; int dly; logic [31:0] dat; } rsp_t;
    rsp_t        rsp_q[$];
    rsp_t        rsp;
    logic        prev_cyc = 1'b0;
    int          beat = 0, acc_rises = 0, acc_hi = 0, gap_len = 0, bad_req = 0;
    int          gaps[$];
    logic [31:0] exp_adr = 0, exp_dat = 0;
    logic        exp_we = 0;

    always @(negedge clk) begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
        if (wb_cyc) begin
            if (!prev_cyc) begin
                beat = 0;
                acc_rises++;
                if (acc_rises > 1) gaps.push_back(gap_len);
            end else
                beat++;
            acc_hi++;
            gap_len = 0;
            if (wb_adr !== exp_adr || wb_we !== exp_we || wb_dat_m2s !== exp_dat ||
                wb_stb !== 1'b1 || wb_sel !== 4'hF || wb_cti !== 3'b000 || wb_bte !== 2'b00)
                bad_req++;
            if (rsp_q.size() > 0 && rsp_q[0].dly == beat) begin
                rsp = rsp_q.pop_front();
                wb_dat_s2m = rsp.dat;
                case (rsp.kind)
                    K_ACK:   wb_ack = 1'b1;
                    K_ERR:   wb_err = 1'b1;
                    K_RTY:   wb_rty = 1'b1;
                    default: begin wb_ack = 1'b1; wb_err = 1'b1; end
                endcase
            end
        end else begin
            gap_len++;
            if (wb_stb) bad_req++;
        end
        prev_cyc = wb_cyc;
    end

    int t_stb = 0;

    task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] wdat);
        @(negedge clk); #1;
        exp_adr = adr; exp_dat = wdat; exp_we = we;
        acc_rises = 0; acc_hi = 0; bad_req = 0; gaps.delete();
        dbg_stb = 1'b1; dbg_we = we; dbg_adr = adr; dbg_wdat = wdat;
        t_stb = cyc_no;
    endtask

    task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic e_err, input logic [31:0] e_rdat, input int hold);
        int start;
        sb_q.push_back('{e_err, e_rdat});
        start = n_acks;
        start_req(we, adr, wdat);
        @(negedge clk); #1;
        dbg_adr = ~adr; dbg_wdat = ~wdat;   // captured already; must not leak onto the bus
        for (int k = 0; k < 1000 && n_acks == start; k++) begin
            @(negedge clk); #1;
        end
        if (n_acks == start) check("ack_wait_expired", 0, 1);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            #1;
            check("state_release_while_held", dut.r_state, RELEASE);
        end
        dbg_stb = 1'b0;
        if (hold > 0) begin
            @(negedge clk); #1;
            check("state_idle_after_release", dut.r_state, IDLE);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acks0;
        rst_n = 1'b0; dbg_stb = 1'b0; dbg_we = 1'b0; dbg_adr = 0; dbg_wdat = 0;
        repeat (3) @(negedge clk);
        check("rst_cyc", {wb_cyc, wb_stb, dbg_ack, dbg_err}, 4'b0);
        check("rst_adr_dat", {wb_adr, wb_dat_m2s}, 64'h0);
        check("rst_rdat_we", {dbg_rdat, 31'h0, wb_we}, 64'h0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_cyc", wb_cyc, 0);

        // 1: zero-wait read
        rsp_q.push_back('{K_ACK, 0, 32'hDEADBEEF});
        access(1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'hDEADBEEF, 0);
        check("t1_latency", t_ack - t_stb, 2);
        check("t1_cycles", acc_rises, 1);
        check("t1_req_fields", bad_req, 0);

        // 2: write with two retries then ack
        rsp_q.push_back('{K_RTY, 0, 32'h0});
        rsp_q.push_back('{K_RTY, 0, 32'h0});
        rsp_q.push_back('{K_ACK, 0, 32'hFFFF_FFFF});
        access(1'b1, 32'h0000_0200, 32'h1234_5678, 1'b0, 32'h0, 0);
        check("t2_cycles", acc_rises, 3);
        check("t2_ngaps", gaps.size(), 2);
        check("t2_gap0", gaps[0], 4);
        check("t2_gap1", gaps[1], 4);
        check("t2_req_stable", bad_req, 0);

        // 3: retries exhausted
        repeat (4) rsp_q.push_back('{K_RTY, 0, 32'h1111_1111});
        access(1'b0, 32'h0000_0300, 32'h0, 1'b1, 32'h0, 0);
        check("t3_cycles", acc_rises, 4);
        check("t3_req_stable", bad_req, 0);

        // 4a: slave never answers
        access(1'b0, 32'h0000_0400, 32'h0, 1'b1, 32'h0, 0);
        check("t4a_cyc_high", acc_hi, 255);
        check("t4a_cycles", acc_rises, 1);

        // 4b: ack in the last cycle before timeout
        rsp_q.push_back('{K_ACK, 254, 32'hCAFE_F00D});
        access(1'b0, 32'h0000_0404, 32'h0, 1'b0, 32'hCAFE_F00D, 0);
        check("t4b_cyc_high", acc_hi, 255);

        // 5: ack+err together, strobe held 10 cycles after ack
        rsp_q.push_back('{K_AE, 1, 32'h5555_AAAA});
        access(1'b0, 32'h0000_0500, 32'h0, 1'b1, 32'h0, 10);
        check("t5_single_cycle", acc_rises, 1);

        // 6: reset in BUS cycle 3
        acks0 = n_acks;
        start_req(1'b1, 32'h0000_0600, 32'h0BAD_0BAD);
        repeat (3) @(negedge clk);
        #1;
        check("t6_cyc_before_rst", wb_cyc, 1);
        rst_n = 1'b0;
        #1;
        check("t6_cyc_async_drop", {wb_cyc, wb_stb}, 2'b00);
        dbg_stb = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_ack", n_acks - acks0, 0);
        rsp_q.delete();
        rsp_q.push_back('{K_ACK, 2, 32'h0});
        access(1'b1, 32'h0000_0604, 32'hA5A5_5A5A, 1'b0, 32'h0, 0);
        check("t6_post_rst_cyc_high", acc_hi, 3);
        check("t6_post_rst_req", bad_req, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
